// File: rtl/reg_bank_sequencer_if.sv
// reg_bank_sequencer_if
// Groups the two requester handshakes and the register-bank drive bus
// that belong to reg_bank_sequencer.
//   Requester side: reqN_i (level), opN_i[2:0], selN_i[1:0], dataN_i[15:0],
//                   ackN_o (one-cycle pulse on the final beat)
//   Bank side:      reg_e_o[3:0] (one-hot enable), reg_fun_sel_o[2:0],
//                   reg_data_o[15:0]
//   Status:         busy_o, grant_id_o, err_o
// Modports: slave = the sequencer, master = whoever drives the requests.
interface reg_bank_sequencer_if;
  logic        req0_i;
  logic        req1_i;
  logic [2:0]  op0_i;
  logic [2:0]  op1_i;
  logic [1:0]  sel0_i;
  logic [1:0]  sel1_i;
  logic [15:0] data0_i;
  logic [15:0] data1_i;
  logic        ack0_o;
  logic        ack1_o;
  logic [3:0]  reg_e_o;
  logic [2:0]  reg_fun_sel_o;
  logic [15:0] reg_data_o;
  logic        busy_o;
  logic        grant_id_o;
  logic        err_o;

  modport slave (
    input  req0_i, req1_i, op0_i, op1_i, sel0_i, sel1_i, data0_i, data1_i,
    output ack0_o, ack1_o, reg_e_o, reg_fun_sel_o, reg_data_o,
           busy_o, grant_id_o, err_o
  );

  modport master (
    output req0_i, req1_i, op0_i, op1_i, sel0_i, sel1_i, data0_i, data1_i,
    input  ack0_o, ack1_o, reg_e_o, reg_fun_sel_o, reg_data_o,
           busy_o, grant_id_o, err_o
  );
endinterface

// File: rtl/reg_bank_sequencer.sv
// reg_bank_sequencer
// Round-robin arbiter and micro-op sequencer that shares a 4 x 16-bit
// register bank between two requesters. Each granted micro-op is decoded
// into a one-hot register enable, a FunSel code and bank input data.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - reg_bank_sequencer_if.slave (request handshakes + bank drive)
// Configuration macro:
//   REG_SEQ_LDW_EN - when defined, op 101 is a two-beat word load (low byte
//                    then high byte) and the BEAT2 state exists; otherwise
//                    op 101 is treated as illegal.
// Every output is a flop (busy_o decodes the state flop only), so there is
// no combinational path from request inputs to the bank.
module reg_bank_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_bank_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef REG_SEQ_LDW_EN
    BEAT2 = 2'd2,
`endif
    BEAT1 = 2'd1
  } state_t;

  // First-beat decode result for one micro-op.
  typedef struct packed {
    logic [3:0]  e;
    logic [2:0]  fs;
    logic [15:0] data;
    logic        two_beat;
    logic        err;
  } beat_t;

  function automatic beat_t decode_first(input logic [2:0] op,
                                         input logic [1:0] sel,
                                         input logic [7:0] lo);
    beat_t b;
    b.e        = 4'b0001 << sel;
    b.fs       = 3'b000;
    b.data     = 16'h0000;
    b.two_beat = 1'b0;
    b.err      = 1'b0;
    case (op)
      3'b000: b.fs = 3'b000;                               // DEC
      3'b001: b.fs = 3'b001;                               // INC
      3'b010: b.fs = 3'b011;                               // CLR
      3'b011: begin b.fs = 3'b100; b.data = {8'h00, lo}; end  // LDB
      3'b100: begin b.fs = 3'b111; b.data = {8'h00, lo}; end  // LDBS
`ifdef REG_SEQ_LDW_EN
      3'b101: begin                                        // LDW low byte
        b.fs       = 3'b100;
        b.data     = {8'h00, lo};
        b.two_beat = 1'b1;
      end
`endif
      default: begin                                       // illegal
        b.e   = 4'b0000;
        b.err = 1'b1;
      end
    endcase
    return b;
  endfunction

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;          // 1: requester 1 holds priority
  logic        grant_q, grant_d;
  logic [3:0]  reg_e_q, reg_e_d;
  logic [2:0]  fs_q, fs_d;
  logic [15:0] data_q, data_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
`ifdef REG_SEQ_LDW_EN
  // Only the second beat of a word load needs anything remembered past grant.
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  hi_q, hi_d;
  logic        ldw_q, ldw_d;
`endif

  logic        win;
  logic [2:0]  w_op;
  logic [1:0]  w_sel;
  logic [15:0] w_data;
  beat_t       first;

  // Requester 1 wins when it is alone or when it holds the pointer.
  assign win    = bus.req1_i & (~bus.req0_i | ptr_q);
  assign w_op   = win ? bus.op1_i   : bus.op0_i;
  assign w_sel  = win ? bus.sel1_i  : bus.sel0_i;
  assign w_data = win ? bus.data1_i : bus.data0_i;
  assign first  = decode_first(w_op, w_sel, w_data[7:0]);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    reg_e_d = 4'b0000;
    fs_d    = 3'b000;
    data_d  = 16'h0000;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
`ifdef REG_SEQ_LDW_EN
    sel_d   = sel_q;
    hi_d    = hi_q;
    ldw_d   = ldw_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0_i | bus.req1_i) begin
          // Beat 1 outputs are computed here so they are registered into
          // the cycle right after the grant edge.
          state_d = BEAT1;
          grant_d = win;
          ptr_d   = ~win;
          reg_e_d = first.e;
          fs_d    = first.fs;
          data_d  = first.data;
          err_d   = first.err;
          if (!first.two_beat) begin
            ack0_d = ~win;
            ack1_d = win;
          end
`ifdef REG_SEQ_LDW_EN
          sel_d = w_sel;
          hi_d  = w_data[15:8];
          ldw_d = first.two_beat;
`endif
        end
      end
      BEAT1: begin
        state_d = IDLE;
`ifdef REG_SEQ_LDW_EN
        if (ldw_q) begin
          // High byte goes in through bank[7:0] with the write-high FunSel.
          state_d = BEAT2;
          reg_e_d = 4'b0001 << sel_q;
          fs_d    = 3'b110;
          data_d  = {8'h00, hi_q};
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
        end
`endif
      end
`ifdef REG_SEQ_LDW_EN
      BEAT2: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      reg_e_q <= 4'b0000;
      fs_q    <= 3'b000;
      data_q  <= 16'h0000;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef REG_SEQ_LDW_EN
      sel_q   <= 2'd0;
      hi_q    <= 8'h00;
      ldw_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      reg_e_q <= reg_e_d;
      fs_q    <= fs_d;
      data_q  <= data_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
`ifdef REG_SEQ_LDW_EN
      sel_q   <= sel_d;
      hi_q    <= hi_d;
      ldw_q   <= ldw_d;
`endif
    end
  end

  assign bus.reg_e_o       = reg_e_q;
  assign bus.reg_fun_sel_o = fs_q;
  assign bus.reg_data_o    = data_q;
  assign bus.ack0_o        = ack0_q;
  assign bus.ack1_o        = ack1_q;
  assign bus.err_o         = err_q;
  assign bus.grant_id_o    = grant_q;
  assign bus.busy_o        = (state_q != IDLE);

endmodule
